car_traffic_scheduler: RTL and testbench
========================================

// Module: car_traffic_scheduler
// PURPOSE
//  Sequences the car lane datapath. A divided tick drives one round-robin burst of one-cycle step strobes (lane0..3).
//  The car datapath therefore needs a single shared adder. Per-lane speeds are derived from the current difficulty level.
//  Game-state FSM (IDLE/RUN/PAUSE/CRASH) gates movement. Sits between the frog/collision logic and the car position registers.
// PARAMETERS
//  TICK_DIV    250000   CLK cycles per movement tick; legal range >= 6
//  MAX_LEVEL   7        level saturates here (4-bit level)
//  CRASH_HOLD  50       ticks spent in CRASH before returning to IDLE
//  LANE_BASE   16'h4321 packed base speeds, lane i = bits [4i+3:4i]
//  SPEED_MAX   15       per-lane speed clamp
// PORTS
//  CLK           in   1   system clock
//  RST_N         in   1   asynchronous, active-low reset
//  i_start       in   1   pulse: IDLE -> RUN
//  i_pause       in   1   level: hold RUN in PAUSE while high
//  i_level_up    in   1   pulse: frog reached goal, level+1
//  i_collision   in   1   pulse: frog hit a car
//  o_lane_step   out  4   one-hot, one-cycle strobe: add speed to that lane
//  o_lane_speed  out  16  packed 4-bit unsigned speed per lane
//  o_lane_dir    out  4   1 = lane moves left (subtract)
//  o_level       out  4   current level
//  o_state       out  2   00 IDLE, 01 RUN, 10 PAUSE, 11 CRASH
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, tick_cnt=0, seq idle, o_lane_step=0, o_level=0.
//   Reset also clears crash timer. o_lane_speed follows level 0.
//  tick_cnt: counts 0..TICK_DIV-1 in RUN and CRASH; frozen in PAUSE; held at 0 in IDLE.
//   Wrap at TICK_DIV-1 produces tick.
//  RUN tick -> o_lane_step = 0001,0010,0100,1000 on the 4 cycles after the wrap cycle, then 0000.
//   Latency is 1 cycle to lane0. Steps are never issued outside a burst.
//  FSM: IDLE--i_start-->RUN.
//   RUN--i_pause-->PAUSE; PAUSE--!i_pause-->RUN.
//   RUN/PAUSE--i_collision-->CRASH.
//   CRASH after CRASH_HOLD ticks -> IDLE, and level cleared to 0.
//   i_start is ignored outside IDLE.
//  Priority, same cycle: i_collision > i_level_up > i_pause > i_start.
//  Pause arriving mid-burst: the burst completes, so no frame is half-updated. The counter freezes once the burst ends.
//  Collision mid-burst: remaining strobes are suppressed from the next cycle.
//  Level: i_level_up in RUN/PAUSE increments o_level, saturating at MAX_LEVEL; ignored in IDLE/CRASH.
//   The speed change takes effect on the next cycle, including mid-burst.
//  Speed: lane i = min(LANE_BASE[i] + o_level, SPEED_MAX). Computed with a 5-bit sum, then clamped. Registered.
//  Car x wrap-around (10-bit) is the datapath's job; this block never sees positions.
// CONFIGURATION
//  CAR_DIR_ALT_EN defined: o_lane_dir = 4'b1010 (odd lanes move left).
//  CAR_DIR_ALT_EN undefined: o_lane_dir = 4'b0000 (all lanes move right).
//  No other behaviour differs between the two builds.
// STRUCTURE
//  constants.v: state encodings, LANE_BASE default, NUM_LANES=4, TICK_DIV default.
//  Sub-module tick_divider: counter plus enable/freeze inputs, producing the 1-cycle tick output.
//  FSM, burst sequencer, and speed/level logic live in this module.
// TESTING (bench: TICK_DIV=8, CRASH_HOLD=2)
//  1. Reset then i_start: the wrap occurs at cycle 8. o_lane_step = 1,2,4,8 on cycles 9-12, then 0 until the next wrap.
//  2. Level up x9 in RUN: o_level saturates at 7. Lane3 speed = min(4+7,15) = 11; lane0 = 8.
//  3. i_pause raised on the lane1 strobe cycle: lanes 2 and 3 still strobe, then no strobes.
//     tick_cnt is frozen; on release, tick_cnt resumes from the frozen value.
//  4. Collision together with level_up on the lane0 cycle: state = CRASH and level unchanged. No further strobes.
//     After 2 ticks: IDLE with level 0.
//  5. RST_N pulsed low mid-burst, asynchronously: o_lane_step = 0 immediately, state = IDLE, level = 0.
//  6. Both builds: o_lane_dir = 1010 with CAR_DIR_ALT_EN, 0000 without. Step timing is identical in both.

Source files
------------

// File: rtl/car_traffic_scheduler_pkg.sv
// car_traffic_scheduler_pkg: game states, parameter defaults and the lane speed helper
package car_traffic_scheduler_pkg;
   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, CRASH = 2'b11} state_t;
   localparam int NUM_LANES = 4;
   localparam int TICK_DIV_DEF = 250000;
   localparam int MAX_LEVEL_DEF = 7;
   localparam int CRASH_HOLD_DEF = 50;
   localparam int SPEED_MAX_DEF = 15;
   localparam logic [15:0] LANE_BASE_DEF = 16'h4321;
   // 5-bit sum per lane so base+level can exceed 15 before the clamp
   function automatic logic [15:0] speeds_of(input logic [15:0] base, input logic [3:0] lvl,
                                             input logic [3:0] smax);
      logic [15:0] s;
      logic [4:0] sum;
      s = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         sum = {1'b0, base[4*i +: 4]} + {1'b0, lvl};
         s[4*i +: 4] = (sum > {1'b0, smax}) ? smax : sum[3:0];
      end
      return s;
   endfunction
endpackage

// File: rtl/car_traffic_scheduler_if.sv
// car_traffic_scheduler_if: game events in, lane step/speed/direction and status out
interface car_traffic_scheduler_if;
   import car_traffic_scheduler_pkg::*;
   logic start;
   logic pause;
   logic level_up;
   logic collision;
   logic [3:0] lane_step;
   logic [15:0] lane_speed;
   logic [3:0] lane_dir;
   logic [3:0] level;
   state_t state;
   modport master (output start, pause, level_up, collision,
                   input lane_step, lane_speed, lane_dir, level, state);
   modport slave (input start, pause, level_up, collision,
                  output lane_step, lane_speed, lane_dir, level, state);
endinterface

// File: rtl/car_traffic_scheduler_tick_divider.sv
// car_traffic_scheduler_tick_divider: movement tick counter with enable (freeze) and clear
module car_traffic_scheduler_tick_divider #(
   parameter int TICK_DIV = 250000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);
   localparam int W = $clog2(TICK_DIV);
   logic [W-1:0] cnt;
   assign tick = en && (cnt == W'(TICK_DIV - 1));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en) cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/car_traffic_scheduler.sv
// car_traffic_scheduler: game FSM, round-robin lane step bursts and level-derived speeds
// CAR_DIR_ALT_EN defined: odd lanes move left; undefined: all lanes move right.
module car_traffic_scheduler
   import car_traffic_scheduler_pkg::*;
#(
   parameter int          TICK_DIV   = TICK_DIV_DEF,
   parameter int          MAX_LEVEL  = MAX_LEVEL_DEF,
   parameter int          CRASH_HOLD = CRASH_HOLD_DEF,
   parameter logic [15:0] LANE_BASE  = LANE_BASE_DEF,
   parameter int          SPEED_MAX  = SPEED_MAX_DEF
) (
   input logic clk,
   input logic rst_n,
   car_traffic_scheduler_if.slave bus
);
   localparam int CW = $clog2(CRASH_HOLD + 1);
   localparam logic [15:0] SPEED_RST = speeds_of(LANE_BASE, 4'd0, 4'(SPEED_MAX));
   state_t state, state_d;
   logic [3:0] level_d, step_d;
   logic [15:0] speed_d;
   logic [CW-1:0] crash_cnt;
   logic tick, busy, active, crash_done;
   assign busy = |bus.lane_step;
   assign active = (state == RUN) || (state == PAUSE);
   assign crash_done = tick && (state == CRASH) && (crash_cnt == CW'(CRASH_HOLD - 1));
   assign bus.state = state;
`ifdef CAR_DIR_ALT_EN
   assign bus.lane_dir = 4'b1010;
`else
   assign bus.lane_dir = 4'b0000;
`endif
   // a pause lets the current burst finish before the counter freezes
   car_traffic_scheduler_tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
      .clk (clk),
      .rst_n (rst_n),
      .en ((state == RUN) || (state == CRASH) || ((state == PAUSE) && busy)),
      .clr (state == IDLE),
      .tick (tick)
   );
   always_comb begin
      state_d = state;
      level_d = bus.level;
      if (active && bus.collision) state_d = CRASH;
      else if (active && bus.level_up)
         level_d = (bus.level >= 4'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : bus.level + 4'd1;
      else if ((state == RUN) && bus.pause) state_d = PAUSE;
      else if ((state == PAUSE) && !bus.pause) state_d = RUN;
      else if ((state == IDLE) && bus.start) state_d = RUN;
      else if (crash_done) begin
         state_d = IDLE;
         level_d = 4'd0;
      end
      step_d = (state_d == CRASH) ? 4'b0000 :
               (tick && (state == RUN)) ? 4'b0001 : {bus.lane_step[2:0], 1'b0};
      speed_d = speeds_of(LANE_BASE, level_d, 4'(SPEED_MAX));
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         bus.level <= 4'd0;
         bus.lane_step <= 4'b0000;
         bus.lane_speed <= SPEED_RST;
         crash_cnt <= '0;
      end else begin
         state <= state_d;
         bus.level <= level_d;
         bus.lane_step <= step_d;
         bus.lane_speed <= speed_d;
         crash_cnt <= (state != CRASH) ? '0 : tick ? crash_cnt + CW'(1) : crash_cnt;
      end
endmodule

// File: tb/tb_car_traffic_scheduler.sv
// tb_car_traffic_scheduler: directed vectors with TICK_DIV=8, CRASH_HOLD=2
module tb_car_traffic_scheduler;
   import car_traffic_scheduler_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int errors = 0;
   int checks = 0;
   logic [3:0] seen;
`ifdef CAR_DIR_ALT_EN
   localparam logic [3:0] DIR_EXP = 4'b1010;
`else
   localparam logic [3:0] DIR_EXP = 4'b0000;
`endif
   car_traffic_scheduler_if bus ();
   car_traffic_scheduler #(.TICK_DIV(8), .CRASH_HOLD(2)) dut (
      .clk (clk),
      .rst_n (rst_n),
      .bus (bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   initial begin
      bus.start = 0;
      bus.pause = 0;
      bus.level_up = 0;
      bus.collision = 0;
      step(3);
      chk("rst_step", bus.lane_step, 0);
      chk("rst_level", bus.level, 0);
      chk("rst_state", bus.state, IDLE);
      chk("rst_speed", bus.lane_speed, 16'h4321);
      chk("dir", bus.lane_dir, DIR_EXP);
      rst_n = 1;
      step(2);
      chk("idle_hold", bus.state, IDLE);
      bus.start = 1;
      step(1);
      bus.start = 0;
      chk("run", bus.state, RUN);
      step(7);
      chk("wrap_c8", bus.lane_step, 0);
      for (int i = 0; i < 4; i++) begin
         step(1);
         chk("burst", bus.lane_step, 32'(1 << i));
      end
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         step(1);
         seen |= bus.lane_step;
      end
      chk("gap_quiet", seen, 0);
      step(1);
      chk("burst2_lane0", bus.lane_step, 1);
      bus.level_up = 1;
      step(1);
      chk("lvl_first", bus.level, 1);
      chk("spd_first", bus.lane_speed, 16'h5432);
      step(8);
      bus.level_up = 0;
      chk("lvl_sat", bus.level, 7);
      chk("spd_sat", bus.lane_speed, 16'hBA98);
      chk("lane1_cycle", bus.lane_step, 2);
      bus.pause = 1;
      step(1);
      chk("pause_state", bus.state, PAUSE);
      chk("pause_lane2", bus.lane_step, 4);
      step(1);
      chk("pause_lane3", bus.lane_step, 8);
      step(1);
      chk("pause_end", bus.lane_step, 0);
      seen = 0;
      for (int i = 0; i < 9; i++) begin
         step(1);
         seen |= bus.lane_step;
      end
      chk("pause_quiet", seen, 0);
      bus.pause = 0;
      step(1);
      chk("resume", bus.state, RUN);
      step(3);
      chk("resume_wrap", bus.lane_step, 0);
      step(1);
      chk("resume_lane0", bus.lane_step, 1);
      bus.collision = 1;
      bus.level_up = 1;
      step(1);
      bus.collision = 0;
      bus.level_up = 0;
      chk("crash", bus.state, CRASH);
      chk("crash_lvl", bus.level, 7);
      chk("crash_nostep", bus.lane_step, 0);
      seen = 0;
      for (int i = 0; i < 14; i++) begin
         step(1);
         seen |= bus.lane_step;
      end
      chk("crash_quiet", seen, 0);
      chk("crash_hold", bus.state, CRASH);
      step(1);
      chk("crash_idle", bus.state, IDLE);
      chk("crash_lvl0", bus.level, 0);
      chk("crash_spd0", bus.lane_speed, 16'h4321);
      bus.start = 1;
      step(1);
      bus.start = 0;
      bus.level_up = 1;
      step(1);
      bus.level_up = 0;
      chk("lvl_one", bus.level, 1);
      step(7);
      chk("run2_lane0", bus.lane_step, 1);
      bus.collision = 1;
      bus.level_up = 1;
      step(1);
      bus.collision = 0;
      bus.level_up = 0;
      chk("prio_state", bus.state, CRASH);
      chk("prio_lvl", bus.level, 1);
      rst_n = 0;
      step(1);
      rst_n = 1;
      bus.start = 1;
      step(1);
      bus.start = 0;
      bus.level_up = 1;
      step(2);
      bus.level_up = 0;
      step(7);
      chk("pre_rst_step", bus.lane_step, 2);
      chk("pre_rst_lvl", bus.level, 2);
      #2 rst_n = 0;
      #1;
      chk("async_step", bus.lane_step, 0);
      chk("async_state", bus.state, IDLE);
      chk("async_lvl", bus.level, 0);
      chk("async_spd", bus.lane_speed, 16'h4321);
      step(1);
      rst_n = 1;
      step(2);
      chk("post_rst", bus.state, IDLE);
      chk("dir_end", bus.lane_dir, DIR_EXP);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
